// File: rtl/inspect_sequencer_if.sv
// Sequencer <-> quality classifier link: latched sensor flags out, one-hot grade back.
interface inspect_sequencer_if;
  logic [2:0] sens_o;      // {color, size, weight}
  logic       sens_vld_o;  // 1-cycle strobe: sens_o newly loaded
  logic [2:0] grade_i;     // one-hot {high, medium, low}

  modport master (
    output sens_o,
    output sens_vld_o,
    input  grade_i
  );

  modport slave (
    input  sens_o,
    input  sens_vld_o,
    output grade_i
  );
endinterface

// File: rtl/inspect_sequencer.sv
// Per-item inspection sequencer: settle, sample sensors, wait for the classifier grade,
// drive the reject diverter. Optional statistics counters under INSPECT_STATS_EN.
module inspect_sequencer #(
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned GRADE_LAT  = 2,
  parameter int unsigned EJECT_CYC  = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 item_i,
  input  logic                 weight_i,
  input  logic                 size_i,
  input  logic                 color_i,
  inspect_sequencer_if.master  cls,
  output logic [1:0]           grade_o,
  output logic                 done_o,
  output logic                 reject_o,
  output logic                 abort_o,
  output logic                 err_o,
  output logic                 busy_o,
  input  logic [1:0]           cnt_sel_i,
  output logic [CNT_W-1:0]     cnt_o
);

  localparam int unsigned MAX_SG  = (SETTLE_CYC > GRADE_LAT) ? SETTLE_CYC : GRADE_LAT;
  localparam int unsigned MAX_CYC = (MAX_SG > EJECT_CYC) ? MAX_SG : EJECT_CYC;
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] GRADE_LAST  = TW'(GRADE_LAT - 1);
  localparam logic [TW-1:0] EJECT_LAST  = TW'(EJECT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_GRADE,
    S_EJECT,
    S_WAIT_CLR
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_item_q;
  logic            r_armed;
  logic [2:0]      r_sens;
  logic            r_sens_vld;
  logic [1:0]      r_grade;
  logic            r_done;
  logic            r_err;
  logic            r_abort;
  logic            r_reject;

  logic            w_rise;
  logic            w_abort;
  logic            w_load;
  logic            w_take;
  logic [1:0]      w_grade_dec;
  logic            w_grade_bad;

  // r_armed stays low after reset until item_i is seen low, so an item that was
  // present across reset must clear and rise again before it is inspected.
  assign w_rise = item_i & ~r_item_q & r_armed;

  always_comb begin
    w_grade_dec = 2'd1;
    w_grade_bad = 1'b0;
    case (cls.grade_i)
      3'b001:  w_grade_dec = 2'd1;
      3'b010:  w_grade_dec = 2'd2;
      3'b100:  w_grade_dec = 2'd3;
      default: w_grade_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + TW'(1);
    w_abort     = 1'b0;
    w_load      = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (!item_i) begin
          w_abort     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == SETTLE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w_load      = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_GRADE;
      end
      S_GRADE: begin
        if (r_cnt == GRADE_LAST) begin
          w_take      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = (w_grade_dec == 2'd1) ? S_EJECT : S_WAIT_CLR;
        end
      end
      S_EJECT: begin
        if (r_cnt == EJECT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_CLR;
        end
      end
      S_WAIT_CLR: begin
        w_cnt_nxt = '0;
        if (!item_i) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_item_q   <= 1'b0;
      r_armed    <= 1'b0;
      r_sens     <= '0;
      r_sens_vld <= 1'b0;
      r_grade    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_abort    <= 1'b0;
      r_reject   <= 1'b0;
    end else begin
      r_item_q   <= item_i;
      r_armed    <= r_armed | ~item_i;
      r_sens_vld <= w_load;
      if (w_load) r_sens <= {color_i, size_i, weight_i};
      r_done     <= w_take;
      r_err      <= w_take & w_grade_bad;
      if (w_take) r_grade <= w_grade_dec;
      r_abort    <= w_abort;
      // Registered from the state, so the diverter rises the cycle after done_o.
      r_reject   <= (r_state == S_EJECT);
    end
  end

  assign cls.sens_o     = r_sens;
  assign cls.sens_vld_o = r_sens_vld;
  assign grade_o        = r_grade;
  assign done_o         = r_done;
  assign err_o          = r_err;
  assign abort_o        = r_abort;
  assign reject_o       = r_reject;
  assign busy_o         = (r_state != S_IDLE);

`ifdef INSPECT_STATS_EN
  logic [CNT_W-1:0] r_stat [4];
  logic [1:0]       w_stat_idx;

  assign w_stat_idx = w_grade_dec - 2'd1;

  // Index 0..2 follow the grade, index 3 counts errors; an error also lands in low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < 4; k++) r_stat[k] <= '0;
    end else if (w_take) begin
      if (r_stat[w_stat_idx] != '1) r_stat[w_stat_idx] <= r_stat[w_stat_idx] + CNT_W'(1);
      if (w_grade_bad && (r_stat[3] != '1)) r_stat[3] <= r_stat[3] + CNT_W'(1);
    end
  end

  assign cnt_o = r_stat[cnt_sel_i];
`else
  logic [1:0] w_unused_sel;
  assign w_unused_sel = cnt_sel_i;
  assign cnt_o        = '0;
`endif

endmodule

// File: tb/tb_inspect_sequencer.sv
// Self-checking bench for inspect_sequencer: schedule-based model plus pinned literals.
module tb_inspect_sequencer;
  localparam int S = 8;
  localparam int G = 2;
  localparam int E = 16;
  localparam int CW = 8;
  localparam int CMAX = 255;
  localparam int NCYC = 8192;
`ifdef INSPECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int K_DONE = 1, K_GRADE = 2, K_REJ = 3, K_BUSY = 4;
  localparam int K_ABORT = 5, K_VLD = 6, K_ERR = 7, K_CNT = 8;

  logic clk = 1'b0;
  logic rst, item_i, weight_i, size_i, color_i;
  logic [1:0] cnt_sel_i;
  logic [1:0] grade_o;
  logic done_o, reject_o, abort_o, err_o, busy_o;
  logic [CW-1:0] cnt_o;

  inspect_sequencer_if cls_if ();

  inspect_sequencer #(
    .SETTLE_CYC(S),
    .GRADE_LAT (G),
    .EJECT_CYC (E),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .item_i   (item_i),
    .weight_i (weight_i),
    .size_i   (size_i),
    .color_i  (color_i),
    .cls      (cls_if),
    .grade_o  (grade_o),
    .done_o   (done_o),
    .reject_o (reject_o),
    .abort_o  (abort_o),
    .err_o    (err_o),
    .busy_o   (busy_o),
    .cnt_sel_i(cnt_sel_i),
    .cnt_o    (cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Expected per-cycle outputs, indexed by number of rising edges seen.
  bit         e_vld   [NCYC];
  bit         e_done  [NCYC];
  bit         e_err   [NCYC];
  bit         e_rej   [NCYC];
  bit         e_abort [NCYC];
  bit         e_busy  [NCYC];
  bit         e_rst   [NCYC];
  logic [2:0] e_sens  [NCYC];
  int         e_gval  [NCYC];
  int         lit_kind[NCYC];
  int         lit_exp [NCYC];

  int n_pass = 0;
  int n_tot  = 0;
  logic [2:0] m_sens  = '0;
  int         m_grade = 0;
  int         mcnt [4] = '{0, 0, 0, 0};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    int exp_cnt;
    if (cyc >= 1 && cyc < NCYC) begin
      if (e_rst[cyc]) begin
        m_sens  = '0;
        m_grade = 0;
        for (int k = 0; k < 4; k++) mcnt[k] = 0;
      end
      if (e_vld[cyc]) m_sens = e_sens[cyc];
      if (e_done[cyc]) begin
        m_grade = e_gval[cyc];
        if (mcnt[m_grade-1] < CMAX) mcnt[m_grade-1]++;
        if (e_err[cyc] && mcnt[3] < CMAX) mcnt[3]++;
      end
      exp_cnt = STATS ? mcnt[cnt_sel_i] : 0;
      check("done",     done_o,            e_done[cyc]);
      check("err",      err_o,             e_err[cyc]);
      check("abort",    abort_o,           e_abort[cyc]);
      check("reject",   reject_o,          e_rej[cyc]);
      check("busy",     busy_o,            e_busy[cyc]);
      check("sens_vld", cls_if.sens_vld_o, e_vld[cyc]);
      check("sens",     cls_if.sens_o,     m_sens);
      check("grade",    grade_o,           m_grade);
      check("cnt",      cnt_o,             exp_cnt);
      case (lit_kind[cyc])
        K_DONE:  check("pin_done",  done_o,            lit_exp[cyc]);
        K_GRADE: check("pin_grade", grade_o,           lit_exp[cyc]);
        K_REJ:   check("pin_rej",   reject_o,          lit_exp[cyc]);
        K_BUSY:  check("pin_busy",  busy_o,            lit_exp[cyc]);
        K_ABORT: check("pin_abort", abort_o,           lit_exp[cyc]);
        K_VLD:   check("pin_vld",   cls_if.sens_vld_o, lit_exp[cyc]);
        K_ERR:   check("pin_err",   err_o,             lit_exp[cyc]);
        K_CNT:   check("pin_cnt",   cnt_o,             lit_exp[cyc]);
        default: ;
      endcase
    end
  end

  function automatic void pin(input int idx, input int kind, input int exp);
    if (idx < NCYC) begin
      lit_kind[idx] = kind;
      lit_exp[idx]  = exp;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sel_pin(input logic [1:0] s, input int exp);
    cnt_sel_i = s;
    pin(cyc, K_CNT, exp);
    step();
  endtask

  // One full item: rise on the next edge, grade g presented only at the sample point,
  // item dropped `extra` cycles after the item reaches WAIT_CLR; optional reset at D+rst_off.
  task automatic inspect(input logic [2:0] sens, input logic [2:0] g, input int extra, input int rst_off);
    int r, d, w, tdrop, last, gv, rs;
    bit bad;
    logic [2:0] decoy;
    r = cyc + 1;
    d = r + S + 1 + G;
    bad = 1'b0;
    case (g)
      3'b001:  gv = 1;
      3'b010:  gv = 2;
      3'b100:  gv = 3;
      default: begin gv = 1; bad = 1'b1; end
    endcase
    w = (gv == 1) ? d + E : d;
    tdrop = w + extra;
    last = (tdrop > w) ? tdrop : w;
    e_vld[r+S+1]  = 1'b1;
    e_sens[r+S+1] = sens;
    e_done[d]     = 1'b1;
    e_gval[d]     = gv;
    e_err[d]      = bad;
    if (gv == 1) for (int i = d + 1; i <= d + E; i++) e_rej[i] = 1'b1;
    for (int i = r; i <= last; i++) e_busy[i] = 1'b1;
    rs = -1;
    if (rst_off >= 0) begin
      rs = d + rst_off;
      for (int i = rs + 1; i < NCYC; i++) begin
        e_vld[i] = 0; e_done[i] = 0; e_err[i] = 0; e_rej[i] = 0;
        e_abort[i] = 0; e_busy[i] = 0; e_rst[i] = 0;
      end
      e_rst[rs+1] = 1'b1;
    end
    decoy = (g == 3'b010) ? 3'b100 : 3'b010;
    item_i = 1'b1;
    {color_i, size_i, weight_i} = sens;
    cls_if.grade_i = decoy;
    while (cyc <= last + 2) begin
      step();
      cls_if.grade_i = (cyc == d - 1) ? g : decoy;
      rst = (cyc == rs);
      if (cyc == tdrop) item_i = 1'b0;
      {color_i, size_i, weight_i} = (cyc >= r + S + 1) ? ~sens : sens;
      cnt_sel_i = 2'(cyc);
    end
  endtask

  task automatic abort_item(input int h);
    int r;
    r = cyc + 1;
    e_abort[r+h] = 1'b1;
    for (int i = r; i < r + h; i++) e_busy[i] = 1'b1;
    item_i = 1'b1;
    {color_i, size_i, weight_i} = 3'b101;
    while (cyc <= r + h + 3) begin
      step();
      if (cyc == r + h - 1) item_i = 1'b0;
      cnt_sel_i = 2'(cyc);
    end
  endtask

  initial begin
    int r;
    rst = 1'b1;
    item_i = 1'b0;
    {color_i, size_i, weight_i} = 3'b000;
    cls_if.grade_i = 3'b000;
    cnt_sel_i = 2'd0;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // High grade: done 11 cycles after the rise, no reject.
    r = cyc + 1;
    pin(r + 9, K_VLD, 1);
    pin(r + 10, K_DONE, 0);
    pin(r + 11, K_DONE, 1);
    pin(r + 12, K_GRADE, 3);
    pin(r + 13, K_REJ, 0);
    inspect(3'b111, 3'b100, 3, -1);

    // Low grade: reject for exactly 16 cycles, busy until item clears.
    r = cyc + 1;
    pin(r + 10, K_REJ, 0);
    pin(r + 11, K_GRADE, 1);
    pin(r + 12, K_REJ, 1);
    pin(r + 27, K_REJ, 1);
    pin(r + 28, K_REJ, 0);
    pin(r + 31, K_BUSY, 1);
    pin(r + 32, K_BUSY, 0);
    inspect(3'b101, 3'b001, 4, -1);

    // Low grade with item leaving during the eject window.
    r = cyc + 1;
    pin(r + 27, K_BUSY, 1);
    pin(r + 28, K_BUSY, 0);
    inspect(3'b010, 3'b001, -10, -1);

    // Medium grade, item leaves right as the grade is reported.
    r = cyc + 1;
    pin(r + 11, K_GRADE, 2);
    pin(r + 12, K_BUSY, 0);
    pin(r + 13, K_REJ, 0);
    inspect(3'b110, 3'b010, 0, -1);

    // Item leaves during settle, then exactly on the terminal settle count.
    r = cyc + 1;
    pin(r + 4, K_ABORT, 0);
    pin(r + 5, K_ABORT, 1);
    pin(r + 6, K_ABORT, 0);
    pin(r + 7, K_BUSY, 0);
    pin(r + 9, K_VLD, 0);
    abort_item(5);
    r = cyc + 1;
    pin(r + 8, K_ABORT, 1);
    pin(r + 9, K_VLD, 0);
    pin(r + 10, K_BUSY, 0);
    abort_item(S);

    // Reset on the third eject cycle while the item stays present.
    r = cyc + 1;
    pin(r + 13, K_REJ, 1);
    pin(r + 14, K_REJ, 0);
    pin(r + 15, K_BUSY, 0);
    pin(r + 16, K_GRADE, 0);
    inspect(3'b111, 3'b001, 30, 2);

    // Multi-hot grade: error plus fail-safe low grade.
    r = cyc + 1;
    pin(r + 10, K_ERR, 0);
    pin(r + 11, K_ERR, 1);
    pin(r + 12, K_GRADE, 1);
    pin(r + 13, K_REJ, 1);
    inspect(3'b011, 3'b011, 1, -1);
    sel_pin(2'd3, STATS ? 1 : 0);
    sel_pin(2'd0, STATS ? 1 : 0);
    sel_pin(2'd2, 0);

    // Medium counter saturation.
    repeat (260) inspect(3'b001, 3'b010, 0, -1);
    sel_pin(2'd1, STATS ? 255 : 0);
    sel_pin(2'd0, STATS ? 1 : 0);
    sel_pin(2'd3, STATS ? 1 : 0);
    sel_pin(2'd2, 0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
